// File: rtl/counter_pkg.sv
// counter_pkg: shared mode constants and op decode type for the up/down counter
package counter_pkg;
  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT = 1'b1;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_UP, OP_DOWN} op_e;
endpackage

// File: rtl/updown_counter_n.sv
// updown_counter_n: WIDTH-bit up/down counter with load, programmable limit, wrap/saturate, tc pulse and sticky ovf
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SATURATE = CNT_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] max,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  localparam bit SAT = (SATURATE == CNT_SAT);
  op_e              w_op;
  logic             w_evt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;
  always_comb begin
    w_op = ld ? OP_LOAD : (inc & ~dec) ? OP_UP : (dec & ~inc) ? OP_DOWN : OP_HOLD;
    w_evt = (w_op == OP_UP && r_q >= max) || (w_op == OP_DOWN && r_q == '0);
    // a count left above a lowered max is pulled back to max on the next down
    w_q = (w_op == OP_LOAD) ? ((data > max) ? max : data)
        : (w_op == OP_UP) ? ((r_q >= max) ? (SAT ? max : '0) : r_q + 1'b1)
        : (w_op == OP_DOWN) ? ((r_q == '0) ? (SAT ? '0 : max) : (r_q > max) ? max : r_q - 1'b1)
        : r_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
      r_tc <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q <= w_q;
      r_tc <= w_evt;
      r_ovf <= w_evt | (r_ovf & ~clr_ovf);
    end
  end
  assign q = r_q;
  assign tc = r_tc;
  assign ovf = r_ovf;
endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised successor to the team's 8-bit up counter. Provides a WIDTH-bit up/down counter with synchronous load and a runtime-programmable upper limit. Supports wrap or saturate mode, a registered terminal-event pulse and a sticky overflow flag. Used as a general event/tick counter wherever the fixed 8-bit up-only counter is too narrow or lacks down/limit control.

Parameters:
WIDTH, 8, counter/data width in bits (legal 2..32)
SATURATE, 0, 0 = wrap at limits, 1 = saturate (hold) at limits
RST_VAL, 0, value of q after reset (must be <= 2^WIDTH-1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
ld  in  1  synchronous load strobe
inc  in  1  count-up request
dec  in  1  count-down request
data  in  WIDTH  load value
max  in  WIDTH  upper count limit (inclusive); lower limit fixed at 0
clr_ovf  in  1  clears sticky ovf
q  out  WIDTH  current count (registered)
tc  out  1  one-cycle terminal-event pulse (registered)
ovf  out  1  sticky limit-crossing flag (registered)

Behaviour:
- Reset (rst=1, async, any time including mid-count): q=RST_VAL, tc=0, ovf=0; held while rst=1. First update on first rising edge with rst=0.
- All updates on rising clk. Inputs are sampled at the edge and the result is visible on q the same edge, so latency is 1 cycle.
- Priority per edge: ld > (inc xor dec) > hold.
  - ld=1: q <= min(data, max); inc/dec ignored; tc=0; ovf unchanged except by clr_ovf.
  - inc=1, dec=1, ld=0: hold; tc=0.
  - inc=0, dec=0, ld=0: hold; tc=0.
- Up (inc=1, dec=0):
  - q < max: q <= q+1; tc=0.
  - q >= max, wrap mode: q <= 0; tc=1; ovf set.
  - q >= max, saturate mode: q <= max; tc=1; ovf set.
- Down (dec=1, inc=0):
  - q > 0 and q <= max: q <= q-1; tc=0.
  - q > max (max lowered at runtime): q <= max; tc=0.
  - q == 0, wrap mode: q <= max; tc=1; ovf set.
  - q == 0, saturate mode: q <= 0; tc=1; ovf set.
- tc is high exactly one cycle per limit event. It is asserted in the same cycle q shows the post-event value. In saturate mode, tc re-pulses on every further request against the limit.
- ovf: set on any limit event, cleared by clr_ovf. If set and clear occur on the same edge, set wins.
- max==0: up in wrap mode yields q=0 with tc=1 every inc. Down behaves the same way.
- Width rules: all arithmetic is modulo 2^WIDTH. No internal width growth is exposed. q never exceeds max except transiently after max is lowered; the next up/down/load corrects it as above.
- With max = 2^WIDTH-1 and SATURATE=0, behaviour equals a plain WIDTH-bit up/down counter. Up-only use reproduces the original 8-bit counter, including 0xFF -> 0x00.

Decomposition:
- Shared package counter_pkg: mode constants CNT_WRAP=0, CNT_SAT=1, and an enumerated type for the next-op decode (OP_HOLD, OP_LOAD, OP_UP, OP_DOWN).
- No sub-module is needed. Op decode, next-value mux and flag logic form a single always_comb plus a single async-reset always_ff.

Test Plan:
- Reset mid-count: WIDTH=8, count up to 0x23, assert rst asynchronously between edges -> q=0x00, tc=0, ovf=0 immediately; after release with inc=1, q=0x01 after the first edge.
- Load priority: ld=1, inc=1, data=250, max=255 -> q=250 and no increment while ld is held; then ld=0 -> 251, 252, ..., 255, 0 with tc=1 on the cycle q=0 and ovf=1.
- Programmable limit wrap: max=9, count up from 0 -> 0..9, 0, with tc=1 at each return to 0. Count down from 0 -> 9 with tc=1.
- Saturate mode: SATURATE=1, max=200, load 198, inc for 5 cycles -> q=199, 200, 200, 200, 200 with tc=1 on the last three. Then dec from 0 -> q stays 0 with tc=1.
- Simultaneous events: inc=dec=1 -> q holds, tc=0. Trigger a limit event with clr_ovf=1 on the same edge -> ovf=1. Next edge with clr_ovf=1 and no event -> ovf=0.
- Runtime max reduction: q=50, max changed to 20, dec=1 -> q=20, tc=0. With q=50 and max=20, inc=1 in wrap mode -> q=0, tc=1. Load data=30 with max=20 -> q=20.
